rv32im_muldiv: RTL and testbench

Iterative multiply/divide unit implementing the eight RV32M operations for the RV32IM core. It sits beside the single-cycle rv32im_alu in the execute stage. The decoder issues an M-extension operation through a valid/ready handshake. The unit returns the 32-bit result after a fixed 34-cycle latency, flagged by a one-cycle done pulse. It uses one shared 64-bit shift/accumulate datapath for both multiply and divide.

---
 rtl/rv32im_muldiv_if.sv | 21 ++
 rtl/rv32im_muldiv.sv | 141 ++++++++++++++
 tb/tb_rv32im_muldiv.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32im_muldiv_if.sv
// Request/response bundle between the decoder and the RV32M multiply/divide unit.
// The decoder drives the request side; the unit returns ready, result and done.
interface rv32im_muldiv_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] operand_1_i;
  logic [31:0] operand_2_i;
  logic [2:0]  op_i;
  logic [31:0] result_o;
  logic        done_o;

  modport master (
    output valid_i, operand_1_i, operand_2_i, op_i,
    input  ready_o, result_o, done_o
  );

  modport slave (
    input  valid_i, operand_1_i, operand_2_i, op_i,
    output ready_o, result_o, done_o
  );
endinterface

// File: rtl/rv32im_muldiv.sv
// Iterative RV32M multiply/divide unit. Operands are converted to magnitudes,
// processed over 32 cycles on one shared 64-bit accumulator (MSB-first
// shift-add for multiply, restoring division for divide), then sign-corrected.
// Latency from accept to done is always 34 cycles.
module rv32im_muldiv #(
  parameter int XLEN = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  rv32im_muldiv_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     a_q, b_q;        // original operands, kept for special cases
  logic [XLEN-1:0]     m1_q, m2_q;      // magnitudes; the one being consumed shifts left
  logic                neg1_q, neg2_q;
  logic [2*XLEN-1:0]   acc_q;           // product, or {remainder, quotient}
  logic [5:0]          cnt_q;
  logic [XLEN-1:0]     result_q;
  logic                done_q;

  logic                sgn1, sgn2, is_div, ovf, div_zero;
  logic [2*XLEN-1:0]   mul_next, div_next, prod;
  logic [XLEN:0]       trial;
  logic [XLEN-1:0]     quo_s, rem_s, fix_res;

  assign is_div   = op_q[2];
  assign div_zero = (b_q == '0);
  assign ovf      = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  // Operand signedness from funct3: MULH, DIV, REM both signed; MULHSU rs1 only.
  always_comb begin
    sgn1 = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
    sgn2 = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
  end

  // One iteration of the shared datapath for multiply and divide.
  always_comb begin
    mul_next = {acc_q[2*XLEN-2:0], 1'b0} + (m2_q[XLEN-1] ? {{XLEN{1'b0}}, m1_q} : '0);
    trial    = {acc_q[2*XLEN-1:XLEN], m1_q[XLEN-1]} - {1'b0, m2_q};
    // A borrow means the shifted remainder stays below the divisor; dropping
    // its top bit is safe because the shifted value is then below 2^XLEN.
    if (trial[XLEN])
      div_next = {acc_q[2*XLEN-2:XLEN], m1_q[XLEN-1], acc_q[XLEN-2:0], 1'b0};
    else
      div_next = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign correction, word selection and special-case overrides.
  always_comb begin
    prod  = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
    quo_s = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s = neg1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:  fix_res = prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  fix_res = prod[2*XLEN-1:XLEN];
      3'b100:  fix_res = div_zero ? '1 : (ovf ? 32'h8000_0000 : quo_s);
      3'b101:  fix_res = div_zero ? '1 : quo_s;
      3'b110:  fix_res = div_zero ? a_q : (ovf ? '0 : rem_s);
      default: fix_res = div_zero ? a_q : rem_s;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.valid_i) state_d = PREP;
      PREP:    state_d = CALC;
      CALC:    if (cnt_q == 6'd31) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture, magnitude conversion, iteration and result load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m1_q     <= '0;
      m2_q     <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      case (state_q)
        IDLE: if (bus.valid_i) begin
          op_q <= bus.op_i;
          a_q  <= bus.operand_1_i;
          b_q  <= bus.operand_2_i;
        end
        PREP: begin
          neg1_q <= sgn1 & a_q[XLEN-1];
          neg2_q <= sgn2 & b_q[XLEN-1];
          m1_q   <= (sgn1 & a_q[XLEN-1]) ? -a_q : a_q;
          m2_q   <= (sgn2 & b_q[XLEN-1]) ? -b_q : b_q;
          acc_q  <= '0;
          cnt_q  <= '0;
        end
        CALC: begin
          if (is_div) begin
            acc_q <= div_next;
            m1_q  <= {m1_q[XLEN-2:0], 1'b0};
          end else begin
            acc_q <= mul_next;
            m2_q  <= {m2_q[XLEN-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 6'd1;
        end
        FIX:     result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.ready_o  = (state_q == IDLE);
  assign bus.result_o = result_q;
  assign bus.done_o   = done_q;

endmodule

// File: tb/tb_rv32im_muldiv.sv
// Scoreboard bench for rv32im_muldiv: the driver pushes hand-computed results,
// a negedge monitor pops and compares them whenever done_o is seen.
module tb_rv32im_muldiv;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_result = '0;

  typedef struct {
    logic [31:0] exp;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  rv32im_muldiv_if bus();

  rv32im_muldiv #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] exp, input string name);
    exp_t e;
    e.exp = exp;
    e.acc_cyc = cyc;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
    int budget = 0;
    @(negedge clk);
    while (!bus.ready_o && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.ready_o) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    bus.valid_i = 1'b1;
    bus.op_i = op;
    bus.operand_1_i = a;
    bus.operand_2_i = b;
    @(posedge clk);
    #1;
    push(exp, name);
    bus.valid_i = 1'b0;
    bus.operand_1_i = 32'hDEAD_BEEF;
    bus.operand_2_i = 32'h0BAD_F00D;
    bus.op_i = ~op;
  endtask

  // Monitor: compare on done, flag spurious pulses, and check result_o holds.
  always @(negedge clk) begin
    if (rst_i) begin
      last_result = '0;
    end else if (bus.done_o) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, bus.result_o, e.exp);
        check({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'd34);
      end
      last_result = bus.result_o;
    end else begin
      check("result_hold", bus.result_o, last_result);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int budget;
    bus.valid_i = 1'b0;
    bus.op_i = 3'b000;
    bus.operand_1_i = '0;
    bus.operand_2_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(bus.ready_o), 32'd1);
    check("reset_done", 32'(bus.done_o), 32'd0);
    check("reset_result", bus.result_o, 32'd0);

    // Multiply, all-ones operands.
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ones");
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ones");
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ones");
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_minmin");

    // Signed and unsigned division of -7 by 2, and 7 by -2.
    issue(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2");
    issue(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2");
    issue(3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, "divu_m7_2");
    issue(3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, "remu_m7_2");
    issue(3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
    issue(3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, "rem_7_m2");

    // Divide by zero.
    issue(3'b100, 32'h0043_8978, 32'h0000_0000, 32'hFFFF_FFFF, "div_zero");
    issue(3'b101, 32'h0043_8978, 32'h0000_0000, 32'hFFFF_FFFF, "divu_zero");
    issue(3'b110, 32'h0043_8978, 32'h0000_0000, 32'h0043_8978, "rem_zero");
    issue(3'b111, 32'h0043_8978, 32'h0000_0000, 32'h0043_8978, "remu_zero");

    // Signed overflow case and its unsigned counterparts.
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
    issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "divu_ovf");
    issue(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "remu_ovf");

    // valid_i held high with changing inputs while busy.
    budget = 0;
    @(negedge clk);
    while (!bus.ready_o && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    bus.valid_i = 1'b1;
    bus.op_i = 3'b000;
    bus.operand_1_i = 32'd3;
    bus.operand_2_i = 32'd5;
    @(posedge clk);
    #1;
    push(32'd15, "busy_first");
    t0 = cyc;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      check("busy_ready_low", 32'(bus.ready_o), 32'd0);
      bus.op_i = 3'($urandom_range(0, 7));
      bus.operand_1_i = $urandom;
      bus.operand_2_i = $urandom;
    end
    @(negedge clk);
    check("busy_ready_back", 32'(bus.ready_o), 32'd1);
    bus.op_i = 3'b101;
    bus.operand_1_i = 32'd100;
    bus.operand_2_i = 32'd7;
    @(posedge clk);
    #1;
    push(32'd14, "busy_second");
    check("busy_second_accept", 32'(cyc - t0), 32'd36);
    bus.valid_i = 1'b0;

    // Asynchronous reset in the middle of a DIV.
    issue(3'b100, 32'h0000_1234, 32'h0000_0011, 32'h0000_0112, "pre_reset_div");
    budget = 0;
    @(negedge clk);
    while (!bus.ready_o && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    bus.valid_i = 1'b1;
    bus.op_i = 3'b100;
    bus.operand_1_i = 32'h7654_3210;
    bus.operand_2_i = 32'h0000_0003;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_i = 1'b1;
    #1;
    check("async_rst_ready", 32'(bus.ready_o), 32'd1);
    check("async_rst_done", 32'(bus.done_o), 32'd0);
    check("async_rst_result", bus.result_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    issue(3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "mulhu_after_rst");

    // Drain the scoreboard.
    budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
